// File: rtl/fc_pkg.sv
// fc_pkg: constants and state encoding shared by the fully-connected layer blocks.
package fc_pkg;
   localparam int FC_WIDTH = 8;
   localparam int FC_IN    = 400;
   typedef enum logic {FILL = 1'b0, FULL = 1'b1} fc_state_e;
   function automatic int fc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fc_input_loader_if.sv
// fc_input_loader_if: activation stream in, assembled vector out, plus framing error flag.
interface fc_input_loader_if
   import fc_pkg::*;
#(
   parameter int WIDTH = FC_WIDTH,
   parameter int IN    = FC_IN
);
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;
   logic [WIDTH-1:0] x [0:IN-1];
   logic             x_valid;
   logic             x_ready;
   logic             err;
   modport slave (input s_data, s_valid, s_last, x_ready, output s_ready, x, x_valid, err);
   modport master (output s_data, s_valid, s_last, x_ready, input s_ready, x, x_valid, err);
endinterface

// File: rtl/fc_input_loader.sv
// fc_input_loader: gathers IN streamed activations into a parallel vector for an FC layer.
// Framing checks on s_last are built only when FC_LAST_CHECK_EN is defined.
module fc_input_loader
   import fc_pkg::*;
#(
   parameter int WIDTH = FC_WIDTH,
   parameter int IN    = FC_IN
) (
   input logic              clk,
   input logic              rst,
   fc_input_loader_if.slave bus
);
   localparam int IW = fc_idx_w(IN);
   localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);
   fc_state_e        r_state;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_x [0:IN-1];
   logic             w_beat;
   logic             w_at_end;
   logic             w_restart;
   assign w_beat   = bus.s_valid && (r_state == FILL);
   assign w_at_end = r_idx == LAST_IDX;
`ifdef FC_LAST_CHECK_EN
   logic r_err;
   // an early s_last drops the partial vector and restarts at element 0
   assign w_restart = bus.s_last && !w_at_end;
   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else if (w_beat && (w_restart || (w_at_end && !bus.s_last))) r_err <= 1'b1;
   end
   assign bus.err = r_err;
`else
   logic w_unused;
   assign w_restart = 1'b0;
   assign w_unused  = bus.s_last;
   assign bus.err   = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
         r_idx   <= '0;
         for (int i = 0; i < IN; i++) r_x[i] <= '0;
      end else if (w_beat) begin
         r_x[r_idx] <= bus.s_data;
         r_idx      <= (w_at_end || w_restart) ? '0 : r_idx + 1'b1;
         if (w_at_end) r_state <= FULL;
      end else if ((r_state == FULL) && bus.x_ready) begin
         r_state <= FILL;
      end
   end
   assign bus.s_ready = r_state == FILL;
   assign bus.x_valid = r_state == FULL;
   assign bus.x       = r_x;
endmodule

// File: tb/tb_fc_input_loader.sv
// tb_fc_input_loader: directed vectors for the activation loader at WIDTH=8, IN=400.
module tb_fc_input_loader;
   localparam int WIDTH = 8;
   localparam int IN    = 400;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   fc_input_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();
   fc_input_loader #(.WIDTH(WIDTH), .IN(IN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // pattern 0: k mod 144, pattern 1: 0xA5, pattern 2: all zero
   function automatic logic [WIDTH-1:0] dv(input int pat, input int k);
      return (pat == 0) ? WIDTH'(k % 144) : (pat == 1) ? 8'hA5 : 8'h00;
   endfunction
   function automatic int xdiff(input int pat);
      int n = 0;
      for (int i = 0; i < IN; i++) if (bus.x[i] !== dv(pat, i)) n++;
      return n;
   endfunction
   task automatic stream(input int pat, input bit gaps, input int k0, input int k1, input int last_k);
      for (int k = k0; k <= k1; k++) begin
         while (gaps && $urandom_range(0, 1) == 1) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'hEE;
            tick();
         end
         if (k == IN - 1) chk("xv_before_last", 32'(bus.x_valid), 0);
         bus.s_valid = 1'b1;
         bus.s_data  = dv(pat, k);
         bus.s_last  = (k == last_k);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask
   task automatic handoff();
      bus.x_ready = 1'b1;
      chk("ho_sready_same", 32'(bus.s_ready), 0);
      tick();
      bus.x_ready = 1'b0;
      chk("ho_xvalid", 32'(bus.x_valid), 0);
      chk("ho_sready", 32'(bus.s_ready), 1);
   endtask
   initial begin
      rst = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h33;
      bus.s_last  = 1'b0;
      bus.x_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      bus.s_valid = 1'b0;
      chk("rst_sready", 32'(bus.s_ready), 1);
      chk("rst_xvalid", 32'(bus.x_valid), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_x", 32'(xdiff(2)), 0);
      stream(0, 1'b0, 0, IN - 1, IN - 1);
      chk("p0_xvalid", 32'(bus.x_valid), 1);
      chk("p0_sready", 32'(bus.s_ready), 0);
      chk("p0_x", 32'(xdiff(0)), 0);
      // s_valid while FULL must not disturb the held vector
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hFF;
      for (int i = 0; i < 5; i++) tick();
      bus.s_valid = 1'b0;
      chk("hold_x", 32'(xdiff(0)), 0);
      chk("hold_xvalid", 32'(bus.x_valid), 1);
      chk("hold_sready", 32'(bus.s_ready), 0);
      handoff();
      bus.x_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.x_ready = 1'b0;
      chk("fill_xready_ign", 32'(bus.x_valid), 0);
      chk("fill_idle_x", 32'(xdiff(0)), 0);
      stream(1, 1'b0, 0, IN - 1, IN - 1);
      chk("a5_xvalid", 32'(bus.x_valid), 1);
      chk("a5_x", 32'(xdiff(1)), 0);
      handoff();
      stream(0, 1'b1, 0, IN - 1, IN - 1);
      chk("gap_xvalid", 32'(bus.x_valid), 1);
      chk("gap_x", 32'(xdiff(0)), 0);
      handoff();
      stream(1, 1'b0, 0, 199, -1);
      rst = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h77;
      tick();
      rst = 1'b0;
      bus.s_valid = 1'b0;
      chk("mid_rst_x", 32'(xdiff(2)), 0);
      chk("mid_rst_xvalid", 32'(bus.x_valid), 0);
      chk("mid_rst_sready", 32'(bus.s_ready), 1);
      stream(0, 1'b0, 0, IN - 1, IN - 1);
      chk("post_rst_xvalid", 32'(bus.x_valid), 1);
      chk("post_rst_x", 32'(xdiff(0)), 0);
      handoff();
      stream(1, 1'b0, 0, 9, 9);
`ifdef FC_LAST_CHECK_EN
      chk("early_last_err", 32'(bus.err), 1);
      chk("early_last_fill", 32'(bus.x_valid), 0);
      stream(0, 1'b0, 0, IN - 1, IN - 1);
      chk("relast_xvalid", 32'(bus.x_valid), 1);
      chk("relast_x", 32'(xdiff(0)), 0);
      handoff();
      chk("err_sticky", 32'(bus.err), 1);
`else
      chk("early_last_err", 32'(bus.err), 0);
      chk("early_last_fill", 32'(bus.x_valid), 0);
      stream(0, 1'b0, 10, IN - 1, IN - 1);
      chk("nolast_xvalid", 32'(bus.x_valid), 1);
      chk("nolast_err", 32'(bus.err), 0);
      for (int i = 0; i < 10; i++) chk("nolast_x_head", 32'(bus.x[i]), 32'(8'hA5));
      chk("nolast_x_tail", 32'(bus.x[IN - 1]), 32'(dv(0, IN - 1)));
      handoff();
`endif
      // back-to-back: x_ready already high on the final beat gives an IN+1 cycle period
      bus.x_ready = 1'b1;
      stream(1, 1'b0, 0, IN - 1, IN - 1);
      chk("b2b_xvalid", 32'(bus.x_valid), 1);
      tick();
      chk("b2b_release", 32'(bus.x_valid), 0);
      chk("b2b_sready", 32'(bus.s_ready), 1);
      bus.x_ready = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
